alu_vector_checker: RTL and testbench

Sequential stimulus/response engine for the 5-bit ALU (S, X, Y in; F, Cout, Overflow out). It accepts test vectors with expected results over a valid/ready stream and drives each vector onto the ALU inputs. After holding them for a programmable settle time, it samples the ALU outputs, compares them with the expected values, and returns a per-vector result over a second valid/ready stream. It sits between a vector source (ROM, UART loader, or bench) and the ALU instance, replacing fixed-delay testbench stimulus with an on-chip self-check.

---
 rtl/alu_vector_checker.sv | 127 ++++++++++++
 tb/tb_alu_vector_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_checker.sv
// Applies queued ALU test vectors, samples the ALU after HOLD cycles and reports a mismatch mask per vector.
// Latency: res_valid rises HOLD cycles after accept; one vector per HOLD+2 cycles at best.
// Backpressure: vec_ready only in IDLE (not while halted with ALU_CHK_STOP_ON_FAIL_EN); result held until res_ready.
module alu_vector_checker #(
    parameter int WIDTH = 5,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [1:0]       vec_s,
    input  logic [WIDTH-1:0] vec_x,
    input  logic [WIDTH-1:0] vec_y,
    input  logic [WIDTH-1:0] vec_exp_f,
    input  logic             vec_exp_cout,
    input  logic             vec_exp_ovf,
    output logic [1:0]       S,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] F,
    input  logic             Cout,
    input  logic             Overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_f,
    output logic             res_cout,
    output logic             res_ovf,
    output logic [2:0]       res_mismatch,
    input  logic             clear,
    output logic             busy,
    output logic [7:0]       vec_count,
    output logic [7:0]       err_count
);
    typedef enum logic [1:0] {IDLE, APPLY, REPORT} state_t;
    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             cout;
        logic             ovf;
    } resp_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);

    state_t     state;
    resp_t      exp_q;
    logic [7:0] hold_cnt;
    logic [2:0] mis_now;
    logic       sample;
    logic       halt;

    assign mis_now   = {F != exp_q.f, Cout != exp_q.cout, Overflow != exp_q.ovf};
    assign sample    = (state == APPLY) && (hold_cnt == 8'd0);
    assign vec_ready = (state == IDLE) && !halt;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            S            <= '0;
            X            <= '0;
            Y            <= '0;
            exp_q        <= '0;
            hold_cnt     <= '0;
            res_valid    <= 1'b0;
            res_f        <= '0;
            res_cout     <= 1'b0;
            res_ovf      <= 1'b0;
            res_mismatch <= '0;
            vec_count    <= '0;
            err_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vec_valid && vec_ready) begin
                        S        <= vec_s;
                        X        <= vec_x;
                        Y        <= vec_y;
                        exp_q    <= {vec_exp_f, vec_exp_cout, vec_exp_ovf};
                        hold_cnt <= HOLD_LD;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    if (sample) begin
                        res_f        <= F;
                        res_cout     <= Cout;
                        res_ovf      <= Overflow;
                        res_mismatch <= mis_now;
                        res_valid    <= 1'b1;
                        vec_count    <= vec_count + 8'd1;
                        if (mis_now != 3'b000 && err_count != 8'hff)
                            err_count <= err_count + 8'd1;
                        state        <= REPORT;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // clear overrides any increment made at the same edge
            if (clear) begin
                vec_count <= '0;
                err_count <= '0;
            end
        end
    end

`ifdef ALU_CHK_STOP_ON_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halt <= 1'b0;
        else if (clear)
            halt <= 1'b0;
        else if (sample && mis_now != 3'b000)
            halt <= 1'b1;
    end
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: plays the ALU itself, driving decoy outputs except in the sampling cycle.
// Fixed vector table, hand sequences for clear/reset/counter limits, then random vectors vs a counting model.
module tb_alu_vector_checker;
    localparam int W    = 5;
    localparam int HOLD = 4;

    logic         clk, rst_n;
    logic         vec_valid, vec_ready;
    logic [1:0]   vec_s;
    logic [W-1:0] vec_x, vec_y, vec_exp_f;
    logic         vec_exp_cout, vec_exp_ovf;
    logic [1:0]   S;
    logic [W-1:0] X, Y, F;
    logic         Cout, Overflow;
    logic         res_valid, res_ready;
    logic [W-1:0] res_f;
    logic         res_cout, res_ovf;
    logic [2:0]   res_mismatch;
    logic         clear, busy;
    logic [7:0]   vec_count, err_count;

    alu_vector_checker #(.WIDTH(W), .HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_s(vec_s), .vec_x(vec_x), .vec_y(vec_y),
        .vec_exp_f(vec_exp_f), .vec_exp_cout(vec_exp_cout), .vec_exp_ovf(vec_exp_ovf),
        .S(S), .X(X), .Y(Y), .F(F), .Cout(Cout), .Overflow(Overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_f(res_f), .res_cout(res_cout), .res_ovf(res_ovf), .res_mismatch(res_mismatch),
        .clear(clear), .busy(busy), .vec_count(vec_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   s;
        logic [W-1:0] x, y, exp_f;
        logic         exp_cout, exp_ovf;
        logic [W-1:0] alu_f;
        logic         alu_cout, alu_ovf;
        logic [2:0]   mis;
        logic [3:0]   rdy;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int mcnt  = 0;
    int merr  = 0;
    bit mhalt = 0;
`ifdef ALU_CHK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] mis_of(input vec_t v);
        return {v.alu_f != v.exp_f, v.alu_cout != v.exp_cout, v.alu_ovf != v.exp_ovf};
    endfunction

    task automatic drive_decoy(input vec_t v);
        F        = ~v.alu_f;
        Cout     = ~v.alu_cout;
        Overflow = ~v.alu_ovf;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic run_vec(input vec_t v, input bit clr_at_sample);
        chk("vec_ready_idle", 32'(vec_ready), 32'(1));
        vec_valid = 1'b1;
        vec_s = v.s; vec_x = v.x; vec_y = v.y;
        vec_exp_f = v.exp_f; vec_exp_cout = v.exp_cout; vec_exp_ovf = v.exp_ovf;
        @(negedge clk);
        vec_valid = 1'b0;
        vec_s = 2'($urandom); vec_x = 5'($urandom); vec_y = 5'($urandom);
        vec_exp_f = 5'($urandom); vec_exp_cout = 1'($urandom); vec_exp_ovf = 1'($urandom);
        chk("S_applied", 32'(S), 32'(v.s));
        chk("X_applied", 32'(X), 32'(v.x));
        chk("Y_applied", 32'(Y), 32'(v.y));
        chk("busy_apply", 32'(busy), 32'(1));
        chk("vec_ready_apply", 32'(vec_ready), 32'(0));
        for (int j = 0; j < HOLD; j++) begin
            chk("res_valid_early", 32'(res_valid), 32'(0));
            chk("X_held", 32'(X), 32'(v.x));
            if (j == HOLD - 1) begin
                F = v.alu_f; Cout = v.alu_cout; Overflow = v.alu_ovf;
                clear = clr_at_sample;
            end else begin
                drive_decoy(v);
            end
            @(negedge clk);
        end
        clear = 1'b0;
        drive_decoy(v);
        if (clr_at_sample) begin
            mcnt = 0; merr = 0; mhalt = 0;
        end else begin
            mcnt = (mcnt + 1) % 256;
            if (v.mis != 3'b000 && merr < 255) merr++;
            if (STOP && v.mis != 3'b000) mhalt = 1;
        end
        chk("res_valid_rise", 32'(res_valid), 32'(1));
        chk("res_f", 32'(res_f), 32'(v.alu_f));
        chk("res_cout", 32'(res_cout), 32'(v.alu_cout));
        chk("res_ovf", 32'(res_ovf), 32'(v.alu_ovf));
        chk("res_mismatch", 32'(res_mismatch), 32'(v.mis));
        chk("vec_count", 32'(vec_count), 32'(mcnt));
        chk("err_count", 32'(err_count), 32'(merr));
        for (int d = 0; d < int'(v.rdy); d++) begin
            @(negedge clk);
            F = F ^ 5'b10101;
            Cout = ~Cout;
            chk("bp_res_valid", 32'(res_valid), 32'(1));
            chk("bp_res_f", 32'(res_f), 32'(v.alu_f));
            chk("bp_vec_ready", 32'(vec_ready), 32'(0));
            chk("bp_busy", 32'(busy), 32'(1));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_fall", 32'(res_valid), 32'(0));
        chk("busy_idle", 32'(busy), 32'(0));
        chk("vec_ready_after", 32'(vec_ready), 32'(!mhalt));
        chk("S_retained", 32'(S), 32'(v.s));
        if (mhalt) begin
            @(negedge clk);
            chk("halt_persists", 32'(vec_ready), 32'(0));
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            mcnt = 0; merr = 0; mhalt = 0;
            chk("halt_released", 32'(vec_ready), 32'(1));
            chk("halt_clr_vec_count", 32'(vec_count), 32'(0));
            chk("halt_clr_err_count", 32'(err_count), 32'(0));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_S"}, 32'(S), 32'(0));
        chk({tag, "_X"}, 32'(X), 32'(0));
        chk({tag, "_Y"}, 32'(Y), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        chk({tag, "_vec_ready"}, 32'(vec_ready), 32'(1));
        chk({tag, "_res_f"}, 32'(res_f), 32'(0));
        chk({tag, "_res_mismatch"}, 32'(res_mismatch), 32'(0));
        chk({tag, "_vec_count"}, 32'(vec_count), 32'(0));
        chk({tag, "_err_count"}, 32'(err_count), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    vec_t tbl [6];

    initial begin
        vec_t v;
        //          s      x         y         exp_f     ec    eo    alu_f     ac    ao    mis     rdy
        tbl[0] = '{2'b00, 5'b00110, 5'b00111, 5'b01101, 1'b0, 1'b0, 5'b01101, 1'b0, 1'b0, 3'b000, 4'd0};
        tbl[1] = '{2'b00, 5'b01110, 5'b00111, 5'b10101, 1'b0, 1'b1, 5'b10101, 1'b0, 1'b0, 3'b001, 4'd0};
        tbl[2] = '{2'b00, 5'b00110, 5'b00111, 5'b01101, 1'b0, 1'b0, 5'b01101, 1'b0, 1'b0, 3'b000, 4'd5};
        tbl[3] = '{2'b01, 5'b10000, 5'b00001, 5'b01111, 1'b1, 1'b1, 5'b01110, 1'b1, 1'b1, 3'b100, 4'd1};
        tbl[4] = '{2'b10, 5'b11111, 5'b10101, 5'b10101, 1'b0, 1'b0, 5'b10101, 1'b1, 1'b0, 3'b010, 4'd2};
        tbl[5] = '{2'b11, 5'b01010, 5'b10101, 5'b11111, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 3'b111, 4'd0};

        rst_n = 1'b0; vec_valid = 1'b0; res_ready = 1'b0; clear = 1'b0;
        vec_s = '0; vec_x = '0; vec_y = '0; vec_exp_f = '0; vec_exp_cout = 1'b0; vec_exp_ovf = 1'b0;
        F = '0; Cout = 1'b0; Overflow = 1'b0;
        #3;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], 1'b0);

        // clear held across the sampling edge: result still reported, counts end at zero
        run_vec(tbl[5], 1'b1);

        // async reset two cycles after accept aborts the vector immediately
        vec_valid = 1'b1;
        vec_s = 2'b01; vec_x = 5'b10101; vec_y = 5'b01011;
        vec_exp_f = 5'b01010; vec_exp_cout = 1'b0; vec_exp_ovf = 1'b0;
        @(negedge clk);
        vec_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        mcnt = 0; merr = 0; mhalt = 0;
        @(negedge clk);
        run_vec(tbl[0], 1'b0);

`ifndef ALU_CHK_STOP_ON_FAIL_EN
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        mcnt = 0; merr = 0;
        for (int i = 0; i < 256; i++) begin
            v = tbl[5];
            v.rdy = 4'd0;
            run_vec(v, 1'b0);
        end
        chk("err_count_saturated", 32'(err_count), 32'(255));
        chk("vec_count_wrapped", 32'(vec_count), 32'(0));
`endif

        for (int i = 0; i < 40; i++) begin
            v.s = 2'($urandom); v.x = 5'($urandom); v.y = 5'($urandom);
            v.exp_f = 5'($urandom); v.exp_cout = 1'($urandom); v.exp_ovf = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                v.alu_f = v.exp_f; v.alu_cout = v.exp_cout; v.alu_ovf = v.exp_ovf;
            end else begin
                v.alu_f = 5'($urandom); v.alu_cout = 1'($urandom); v.alu_ovf = 1'($urandom);
            end
            v.mis = mis_of(v);
            v.rdy = 4'($urandom_range(0, 3));
            run_vec(v, (i % 10) == 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
